data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
- Parametrised, handshaked successor to the single-cycle data memory.
- Serves RV32 loads and stores (byte/half/word, signed/unsigned) against a byte-addressed, word-organised array.
- Provides byte-lane write enables, alignment and range fault detection, and a programmable wait-state latency.
- Sits between the load/store unit and backing RAM in the single-cycle and upcoming multi-cycle CPUs.

Parameters:
- ADDR_WIDTH, 32: width of the byte address.
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_1000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response, range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; the value sits in the low bits for the chosen size.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  request was misaligned, out of range, or used a reserved size.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset, reset.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, wait counter 0. Memory contents are not reset.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. req_ready=1 only in IDLE. Request fields are captured at acceptance and may change afterwards.
- States:
  - IDLE: on accept, go to WAIT if WAIT_CYCLES>0, else RESP. Load the counter with WAIT_CYCLES.
  - WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter reaches 1.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. There is no response back-pressure.
- Latency: resp_valid asserts WAIT_CYCLES+1 cycles after the accept edge. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Address decode:
  - offset = req_addr - BASE_ADDR.
  - In range iff req_addr >= BASE_ADDR and offset < DEPTH_WORDS*4.
  - word index = offset[log2(DEPTH_WORDS)+1:2].
  - lane = offset[1:0].
- Fault conditions, any of:
  - out of range;
  - req_size=11;
  - half with lane[0]=1;
  - word with lane!=0.
  - On fault: no write, resp_rdata=0, resp_fault=1. Fault is reported with the same latency as a normal response.
- Store:
  - Byte enables: byte → 1 lane at `lane`; half → lanes lane, lane+1; word → all 4.
  - Data is replicated so that req_wdata[7:0] or req_wdata[15:0] lands on the enabled lanes. Non-enabled bytes are unchanged.
  - The write commits on the accept edge.
  - resp_rdata=0, resp_fault=0.
- Load:
  - The word is read from the array on the edge entering RESP and registered into resp_rdata.
  - The selected byte or half is shifted to bit 0, then sign- or zero-extended per req_unsigned. req_unsigned is ignored for words.
- Ordering: a load accepted after a store's accept edge returns the stored data.
- Reset mid-operation: a reset asserted in WAIT or RESP forces IDLE and suppresses any pending resp_valid. A store already accepted stays committed.
- Simultaneous events: reset takes priority over accept. A request presented in RESP is not accepted (req_ready=0).

Test Plan:
- Word round trip, WAIT_CYCLES=0, BASE=0x1000: store word 0xDEADBEEF at 0x101C → resp_valid exactly 1 cycle after accept, fault=0. Then load word 0x101C → resp_rdata=0xDEADBEEF.
- Byte/half extension: after the above, LB 0x101C → 0xFFFFFFEF; LBU 0x101F → 0x000000DE; LH 0x101E → 0xFFFFDEAD; LHU 0x101C → 0x0000BEEF.
- Partial stores: SB 0x55 to 0x101D, then SH 0x1234 to 0x101E → load word 0x101C returns 0x123455EF.
- Faults: word load at 0x1002, half store at 0x1001, size=11, and addr 0x0FFC or 0x1000+DEPTH_WORDS*4 → each gives resp_fault=1 and resp_rdata=0, with the memory word unchanged.
- Wait states, WAIT_CYCLES=3: req_ready falls after accept. resp_valid rises exactly 4 cycles after accept. req_ready returns the cycle after resp_valid. req_valid held high throughout is accepted only in IDLE.
- Reset mid-op, WAIT_CYCLES=3: accept a store of 0xA5A5A5A5, assert reset for 1 cycle during WAIT → no resp_valid, req_ready=1 after reset. A subsequent load of that address returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Handshaked RV32 data memory: byte/half/word loads and stores against a word array,
// with byte-lane enables, alignment/range faults and a fixed number of wait states.
module data_memory_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault
);

  localparam int unsigned         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // request decode, evaluated on the live request fields
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned;
  logic                  fault;
  logic                  accept;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wdata_lanes;

  assign offset     = req_addr - BASE_ADDR;
  assign in_range   = (req_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign lane       = offset[1:0];
  assign idx        = offset[IDX_W+1:2];
  assign misaligned = ((req_size == SZ_HALF) && lane[0]) ||
                      ((req_size == SZ_WORD) && (lane != 2'b00));
  assign fault      = !in_range || (req_size == SZ_RSVD) || misaligned;
  assign accept     = req_valid && req_ready;
  assign wr_en      = accept && req_write && !fault && !reset;

  always_comb begin
    be          = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be          = 4'b0011 << lane;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // stores commit on the accept edge, so a later load always sees them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  // request fields held for the wait-state path
  logic             wr_q, uns_q, fault_q;
  logic [1:0]       size_q, lane_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      idx_q   <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      uns_q   <= req_unsigned;
      fault_q <= fault;
      size_q  <= req_size;
      lane_q  <= lane;
      idx_q   <= idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // with zero wait states RESP is entered on the accept edge, so read from the live fields
  logic             sel_wr, sel_uns, sel_fault;
  logic [1:0]       sel_size, sel_lane;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      rd_word, rd_shift, load_data;

  always_comb begin
    if (state_q == S_IDLE) begin
      sel_wr    = req_write;
      sel_uns   = req_unsigned;
      sel_fault = fault;
      sel_size  = req_size;
      sel_lane  = lane;
      sel_idx   = idx;
    end else begin
      sel_wr    = wr_q;
      sel_uns   = uns_q;
      sel_fault = fault_q;
      sel_size  = size_q;
      sel_lane  = lane_q;
      sel_idx   = idx_q;
    end
    rd_word  = mem_q[sel_idx];
    rd_shift = rd_word >> {sel_lane, 3'b000};
    case (sel_size)
      SZ_BYTE: load_data = {{24{~sel_uns & rd_shift[7]}},  rd_shift[7:0]};
      SZ_HALF: load_data = {{16{~sel_uns & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  always_comb begin
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      resp_fault_d = sel_fault;
      resp_rdata_d = (sel_wr || sel_fault) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule
